// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions for the fetch slice: widths, reset/NOP words,
// stall vector indices and the IF/ID payload type.
package inst_fetch_pkg;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam word_t NOP_INST_DEF = 32'h0000_0000;
    localparam addr_t RESET_PC_DEF = 32'h0000_0000;

    // Stall vector layout as driven by the hazard/control unit.
    localparam int STALL_IF = 0;
    localparam int STALL_ID = 1;
    localparam int STALL_W  = 2;

    typedef struct packed {
        addr_t pc;
        word_t inst;
    } if_id_t;

    // Redirects are forced to word alignment; no misalignment trap here.
    function automatic addr_t word_align(addr_t a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// Instruction ROM bus: fetch stage is master, ROM answers combinationally.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic  rom_ce;
    addr_t rom_addr;
    word_t rom_inst;

    modport master (output rom_ce, output rom_addr, input  rom_inst);
    modport slave  (input  rom_ce, input  rom_addr, output rom_inst);
endinterface

// File: rtl/inst_fetch_if_id.sv
// IF/ID pipeline register with flush, bubble and hold.
module inst_fetch_if_id
    import inst_fetch_pkg::*;
#(
    parameter word_t NOP_INST = NOP_INST_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               rom_ce,
    input  addr_t              pc,
    input  word_t              rom_inst,
    output if_id_t             id
);
    localparam if_id_t BUBBLE = '{pc: '0, inst: NOP_INST};

    logic   s_if, s_id;
    if_id_t id_next;

    assign s_if = stall[STALL_IF];
    assign s_id = stall[STALL_ID];

    // Flush and IF-only stall inject a bubble; stall_id (legal or not) holds.
    always_comb begin
        id_next = id;
        if (flush)
            id_next = BUBBLE;
        else if (s_if && !s_id)
            id_next = BUBBLE;
        else if (!s_if && !s_id)
            id_next = '{pc: pc, inst: (rom_ce ? rom_inst : NOP_INST)};
    end

    // Register update; reset presents a NOP at PC 0 immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            id <= BUBBLE;
        else
            id <= id_next;
    end

    // Control must never stall ID while IF keeps advancing.
    a_no_id_only_stall: assert property (@(posedge clk) disable iff (!rst_n)
        !(s_id && !s_if));
endmodule

// File: rtl/inst_fetch_pc_reg.sv
// Program counter, ROM chip-enable and next-PC selection.
module inst_fetch_pc_reg
    import inst_fetch_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall_if,
    input  logic  branch_flag,
    input  addr_t branch_target,
    input  logic  flush,
    input  addr_t flush_pc,
    output logic  ce,
    output addr_t pc
);
    addr_t pc_next;

    // Next PC: flush > stall > branch > sequential; frozen until ce is up.
    always_comb begin
        pc_next = pc;
        if (ce) begin
            if (flush)
                pc_next = word_align(flush_pc);
            else if (!stall_if) begin
                if (branch_flag)
                    pc_next = word_align(branch_target);
                else
                    pc_next = pc + 32'd4;
            end
        end
    end

    // ce comes up one edge after reset release, so the first fetch of
    // RESET_PC happens in the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            ce <= 1'b0;
        end else begin
            pc <= pc_next;
            ce <= 1'b1;
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC/ROM driver plus IF/ID register, with MIPS
// one-instruction branch delay slot (the word fetched alongside a taken
// branch in ID flows on unsquashed).
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEF,
    parameter word_t NOP_INST = NOP_INST_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           stall_if,
    input  logic           stall_id,
    input  logic           branch_flag,
    input  addr_t          branch_target,
    input  logic           flush,
    input  addr_t          flush_pc,
    inst_fetch_if.master   rom,
    output addr_t          id_pc,
    output word_t          id_inst
);
    logic [STALL_W-1:0] stall;
    logic               ce;
    addr_t              pc;
    if_id_t             id;

    assign stall[STALL_IF] = stall_if;
    assign stall[STALL_ID] = stall_id;

    inst_fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_if      (stall_if),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .ce            (ce),
        .pc            (pc)
    );

    inst_fetch_if_id #(.NOP_INST(NOP_INST)) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .flush    (flush),
        .rom_ce   (ce),
        .pc       (pc),
        .rom_inst (rom.rom_inst),
        .id       (id)
    );

    assign rom.rom_ce   = ce;
    assign rom.rom_addr = pc;
    assign id_pc        = id.pc;
    assign id_inst      = id.inst;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: table of per-cycle inputs and expected
// registered outputs, plus hand-written reset sequences.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam word_t NOP = 32'h0000_0000;
    localparam int    NV  = 20;

    typedef struct packed {
        logic  si;
        logic  sd;
        logic  br;
        addr_t tgt;
        logic  fl;
        addr_t fpc;
        logic  e_ce;
        addr_t e_addr;
        addr_t e_idpc;
        word_t e_inst;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  stall_if = 1'b0, stall_id = 1'b0, branch_flag = 1'b0, flush = 1'b0;
    addr_t branch_target = '0, flush_pc = '0;
    addr_t id_pc;
    word_t id_inst;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NV];

    inst_fetch_if rom_bus ();

    // ROM model: address-tagged word, never equal to NOP.
    function automatic word_t rom_word(addr_t a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign rom_bus.rom_inst = rom_word(rom_bus.rom_addr);

    inst_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .rom           (rom_bus.master),
        .id_pc         (id_pc),
        .id_inst       (id_inst)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic si, logic sd, logic br, addr_t tgt,
                                logic fl, addr_t fpc, logic ce, addr_t a,
                                addr_t ip, word_t ii);
        vec_t v;
        v = '{si, sd, br, tgt, fl, fpc, ce, a, ip, ii};
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic ce, addr_t a, addr_t ip, word_t ii);
        chk({tag, ".rom_ce"},   {31'd0, rom_bus.rom_ce}, {31'd0, ce});
        chk({tag, ".rom_addr"}, rom_bus.rom_addr, a);
        chk({tag, ".id_pc"},    id_pc, ip);
        chk({tag, ".id_inst"},  id_inst, ii);
    endtask

    task automatic drive_idle();
        stall_if = 0; stall_id = 0; branch_flag = 0; branch_target = '0;
        flush = 0; flush_pc = '0;
    endtask

    initial begin
        //             si sd br tgt           fl fpc           ce addr          id_pc         id_inst
        vecs[0]  = mk(0, 0, 1, 32'h40,        0, 0,            0, 32'h0,        32'h0,        NOP);  // branch ignored while ce=0
        vecs[1]  = mk(0, 0, 0, 0,             0, 0,            1, 32'h0,        32'h0,        NOP);
        vecs[2]  = mk(0, 0, 0, 0,             0, 0,            1, 32'h4,        32'h0,        rom_word(32'h0));
        vecs[3]  = mk(0, 0, 0, 0,             0, 0,            1, 32'h8,        32'h4,        rom_word(32'h4));
        vecs[4]  = mk(0, 0, 1, 32'h40,        0, 0,            1, 32'hC,        32'h8,        rom_word(32'h8));  // branch in ID at 8
        vecs[5]  = mk(0, 0, 0, 0,             0, 0,            1, 32'h40,       32'hC,        rom_word(32'hC));  // delay slot in ID
        vecs[6]  = mk(0, 0, 1, 32'h13,        0, 0,            1, 32'h44,       32'h40,       rom_word(32'h40)); // misaligned target
        vecs[7]  = mk(1, 1, 0, 0,             0, 0,            1, 32'h10,       32'h44,       rom_word(32'h44));
        vecs[8]  = mk(1, 1, 1, 32'h80,        0, 0,            1, 32'h10,       32'h44,       rom_word(32'h44)); // branch+stall: pc holds
        vecs[9]  = mk(1, 1, 0, 0,             0, 0,            1, 32'h10,       32'h44,       rom_word(32'h44));
        vecs[10] = mk(0, 0, 0, 0,             0, 0,            1, 32'h10,       32'h44,       rom_word(32'h44));
        vecs[11] = mk(1, 0, 0, 0,             0, 0,            1, 32'h14,       32'h10,       rom_word(32'h10)); // bubble
        vecs[12] = mk(0, 0, 0, 0,             0, 0,            1, 32'h14,       32'h0,        NOP);
        vecs[13] = mk(1, 1, 1, 32'h40,        1, 32'h183,      1, 32'h18,       32'h14,       rom_word(32'h14)); // flush wins
        vecs[14] = mk(0, 0, 0, 0,             0, 0,            1, 32'h180,      32'h0,        NOP);
        vecs[15] = mk(0, 0, 0, 0,             0, 0,            1, 32'h184,      32'h180,      rom_word(32'h180));
        vecs[16] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0,            1, 32'h188,      32'h184,      rom_word(32'h184));
        vecs[17] = mk(0, 0, 0, 0,             0, 0,            1, 32'hFFFF_FFFC, 32'h188,     rom_word(32'h188));
        vecs[18] = mk(0, 0, 0, 0,             0, 0,            1, 32'h0,        32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC)); // wrap
        vecs[19] = mk(0, 0, 1, 32'h24,        0, 0,            1, 32'h4,        32'h0,        rom_word(32'h0));

        // Reset state while rst_n is low.
        drive_idle();
        repeat (2) @(negedge clk);
        #1 chk_all("reset", 1'b0, 32'h0, 32'h0, NOP);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            stall_if = vecs[i].si; stall_id = vecs[i].sd;
            branch_flag = vecs[i].br; branch_target = vecs[i].tgt;
            flush = vecs[i].fl; flush_pc = vecs[i].fpc;
            #1 chk_all($sformatf("vec%0d", i), vecs[i].e_ce, vecs[i].e_addr,
                       vecs[i].e_idpc, vecs[i].e_inst);
            @(negedge clk);
        end

        // Mid-stream async reset at pc=0x24.
        drive_idle();
        #1 chk_all("pre_rst", 1'b1, 32'h24, 32'h4, rom_word(32'h4));
        #1 rst_n = 1'b0;
        #1 chk_all("async_rst", 1'b0, 32'h0, 32'h0, NOP);
        @(posedge clk);
        #1 chk_all("rst_held", 1'b0, 32'h0, 32'h0, NOP);

        // Start-up repeats.
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_all("restart0", 1'b0, 32'h0, 32'h0, NOP);
        @(negedge clk);
        #1 chk_all("restart1", 1'b1, 32'h0, 32'h0, NOP);
        @(negedge clk);
        #1 chk_all("restart2", 1'b1, 32'h4, 32'h0, rom_word(32'h0));
        @(negedge clk);
        #1 chk_all("restart3", 1'b1, 32'h8, 32'h4, rom_word(32'h4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch initiator that drives the combinational instruction ROM (`ce`/`addr`/`inst`).
- Holds the PC, generates ROM chip-enable and byte address, and selects the next PC: sequential, branch redirect, flush redirect, or stall hold.
- Registers the fetched word and its PC into the IF/ID pipeline register for the decode stage.
- Implements MIPS-style one-instruction branch delay slot semantics.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset and first fetch address.
- NOP_INST, 32'h0000_0000, word injected into ID on a bubble or flush.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_if  in  1  hold PC; IF stage must not advance.
- stall_id  in  1  hold the IF/ID register contents.
- branch_flag  in  1  ID resolved a taken branch/jump this cycle.
- branch_target  in  32  byte address of the taken branch.
- flush  in  1  exception/flush request; highest priority.
- flush_pc  in  32  redirect address on flush.
- rom_ce  out  1  ROM chip enable.
- rom_addr  out  32  ROM byte address (equals pc).
- rom_inst  in  32  ROM data, combinational from rom_addr.
- id_pc  out  32  PC of the instruction presented to ID.
- id_inst  out  32  instruction presented to ID.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, rom_ce=0, id_pc=0, id_inst=NOP_INST.
  - All outputs take these values immediately, not at the next edge.
- Start-up:
  - First rising edge with rst_n=1 sets rom_ce<=1; pc stays RESET_PC.
  - While rom_ce=0, pc is held at RESET_PC regardless of other inputs.
  - The first valid fetch therefore occurs in the cycle after reset release.
- rom_addr = pc (combinational). ROM word is valid in the same cycle. Fetch latency to ID is 1 edge.
- Next-PC priority (evaluated only when rom_ce=1):
  1. flush=1: pc <= {flush_pc[31:2],2'b00}.
  2. stall_if=1: pc holds.
  3. branch_flag=1: pc <= {branch_target[31:2],2'b00}.
  4. Otherwise pc <= pc+4. Wraps 32'hFFFF_FFFC -> 0, no flag.
- Delay slot:
  - When branch_flag is asserted, the instruction fetched in that same cycle (pc of branch+4) is the delay slot.
  - It is captured into ID normally, not squashed.
  - The target is fetched in the next cycle.
- IF/ID register update, in priority order:
  - flush=1: id_pc<=0, id_inst<=NOP_INST.
  - stall_if=1 and stall_id=0: bubble, id_pc<=0, id_inst<=NOP_INST.
  - stall_if=1 and stall_id=1: hold both.
  - stall_if=0: id_pc<=pc, id_inst<=(rom_ce ? rom_inst : NOP_INST).
  - stall_if=0 with stall_id=1 is an illegal combination from control. Treat it as hold and flag it with an assertion.
- Simultaneous events:
  - flush overrides stall and branch in the same cycle.
  - branch_flag together with stall_if: the branch is lost, so control must keep branch_flag asserted until the stall clears. The bench checks PC hold.
- Reset mid-operation: all state returns to reset values asynchronously. No partial fetch is delivered.
- Misaligned addresses: bits [1:0] of any redirect are forced to 0. No exception is raised here.

Decomposition:
- Shared package (cpu_defs):
  - 32-bit word/address widths.
  - NOP_INST.
  - RESET_PC.
  - Stall vector bit indices (IF, ID).
- Sub-module pc_reg: PC, rom_ce, next-PC mux.
- Sub-module if_id: pipeline register with bubble/hold/flush.
- inst_fetch instantiates both and owns no other state.

Test Plan:
- Reset release, no stalls, ROM returns addr-based pattern:
  - rom_ce rises 1 edge after rst_n=1.
  - rom_addr sequence 0,0,4,8,C.
  - id_pc/id_inst follow 1 edge later.
- Branch at pc=8 with branch_flag=1, target 0x40:
  - Delay slot 0xC reaches ID.
  - Next fetch is 0x40, then 0x44.
- stall_if=1, stall_id=1 for 3 cycles at pc=0x10:
  - pc holds 0x10.
  - id_pc/id_inst unchanged.
  - Resumes at 0x14 after release.
- stall_if=1, stall_id=0 for 1 cycle: ID receives id_pc=0, id_inst=NOP_INST, and pc holds.
- flush=1 with flush_pc=0x0000_0183 while branch_flag=1 and stall_if=1:
  - pc -> 0x180.
  - ID gets NOP_INST.
  - Next fetch is 0x184.
- rst_n pulsed low mid-stream at pc=0x24: rom_ce=0, pc=RESET_PC, id_inst=NOP_INST immediately, then start-up repeats.
